// File: rtl/i2s_pkg.sv
// ----------------------------------------------------------------------------
// i2s_pkg
//
// Shared types and elaboration-time helpers for the I2S/TDM transmitter.
//   mode_e      : serial alignment (I2S one-bit delay, or left-justified)
//   frame_bits  : bits per frame = slot width * slots per frame
//   pos_bits    : width of the frame position counter
// ----------------------------------------------------------------------------
package i2s_pkg;

    typedef enum logic {
        I2S_MODE = 1'b0,
        LJ_MODE  = 1'b1
    } mode_e;

    function automatic int frame_bits(input int width, input int channels);
        return width * channels;
    endfunction

    function automatic int pos_bits(input int width, input int channels);
        return $clog2(width * channels);
    endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// ----------------------------------------------------------------------------
// i2s_tx_fifo
//
// Synchronous frame FIFO. Head entry is presented combinationally on rd_data.
// Push into a full FIFO and pop from an empty FIFO are ignored.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high; empties the FIFO
//   push     in   write wr_data at the tail
//   pop      in   discard the head entry
//   wr_data  in   DW-bit frame
//   rd_data  out  DW-bit head frame (valid when !empty)
//   full     out  DEPTH entries held
//   empty    out  no entries held
// ----------------------------------------------------------------------------
module i2s_tx_fifo
    import i2s_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are meaningful, so clearing the data adds nothing.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_tdm_transmitter.sv
// ----------------------------------------------------------------------------
// i2s_tdm_transmitter
//
// I2S / TDM serial audio transmitter in the SCK domain. Whole frames of
// CHANNELS slots are queued in a frame FIFO and shifted out MSB-first, with
// WS high for the second half of each frame.
//
// Ports:
//   SCK         in   bit clock, all logic on the rising edge
//   reset       in   synchronous, active-high
//   LoadData    in   frame; slot 0 in the MSBs, slot CHANNELS-1 in the LSBs
//   LoadValid   in   LoadData valid; push happens on LoadValid && Ready
//   Ready       out  FIFO not full (registered)
//   Mode        in   0 = I2S (one-bit delay), 1 = left-justified;
//                    sampled only at frame boundaries
//   SerialData  out  serial data, MSB first
//   WS          out  word select / frame sync
//   Underrun    out  one-cycle pulse: frame boundary reached with FIFO empty
//
// Build option:
//   I2S_TX_REPEAT_ON_UNDERRUN_EN  when defined, an underrun retransmits the
//                                 last popped frame (zeros if none since
//                                 reset) instead of zeros.
// ----------------------------------------------------------------------------
module i2s_tdm_transmitter
    import i2s_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      SCK,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] LoadData,
    input  logic                      LoadValid,
    output logic                      Ready,
    input  logic                      Mode,
    output logic                      SerialData,
    output logic                      WS,
    output logic                      Underrun
);

    localparam int F  = frame_bits(WIDTH, CHANNELS);
    localparam int PW = pos_bits(WIDTH, CHANNELS);

    localparam logic [PW-1:0] POS_LAST = PW'(F - 1);
    localparam logic [PW-1:0] POS_HALF = PW'(F / 2);

    logic [PW-1:0] pos;
    logic [F-1:0]  shreg;
    logic          delay_bit;    // previous cycle's left-justified bit
    mode_e         mode_q;
    logic          underrun_q;

    logic          boundary;
    logic          push;
    logic          pop;
    logic [F-1:0]  head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [F-1:0]  next_frame;

    assign boundary = (pos == POS_LAST);
    assign push     = LoadValid && Ready;
    assign pop      = boundary && !fifo_empty;
    assign Ready    = !fifo_full;

    i2s_tx_fifo #(
        .DW    (F),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (SCK),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (LoadData),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    logic [F-1:0] last_frame;

    always_ff @(posedge SCK) begin
        if (reset) begin
            last_frame <= '0;
        end else if (pop) begin
            last_frame <= head;
        end
    end

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_frame = last_frame;
        if (!fifo_empty) begin
            next_frame = head;
        end
    end
`else
    always_comb begin
        next_frame = '0;
        if (!fifo_empty) begin
            next_frame = head;
        end
    end
`endif

    always_ff @(posedge SCK) begin
        if (reset) begin
            pos        <= '0;
            shreg      <= '0;
            delay_bit  <= 1'b0;
            mode_q     <= I2S_MODE;
            underrun_q <= 1'b0;
        end else begin
            // Capturing the outgoing MSB every cycle gives the I2S stream:
            // at Pos 0 this holds the last bit of the previous frame.
            delay_bit  <= shreg[F-1];
            underrun_q <= 1'b0;
            if (boundary) begin
                pos        <= '0;
                shreg      <= next_frame;
                mode_q     <= mode_e'(Mode);
                underrun_q <= fifo_empty;
            end else begin
                pos   <= pos + PW'(1);
                shreg <= {shreg[F-2:0], 1'b0};
            end
        end
    end

    assign SerialData = (mode_q == LJ_MODE) ? shreg[F-1] : delay_bit;
    assign WS         = (pos >= POS_HALF);
    assign Underrun   = underrun_q;

endmodule
